bmem_responder: RTL

Cycle-accurate burst-memory responder for the core's `bmem_*` port. It accepts line-granular (32-byte) read and write requests, returns read lines as four 64-bit beats after a fixed latency, and absorbs write lines as four 64-bit beats. It sits opposite the CPU top level in the core testbench and in the FPGA memory shim, and replaces the behavioural memory model so that back-pressure and pipelined reads are exercised deterministically.

---
 rtl/bmem_pkg.sv | 20 ++
 rtl/bmem_rd_queue.sv | 59 +++++
 rtl/bmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the burst-memory responder.
// A memory line is four 64-bit beats.
package bmem_pkg;

   localparam int BMEM_BEATS      = 4;
   localparam int BMEM_LINE_BYTES = 32;

   typedef enum logic {W_IDLE, W_BEAT} wstate_t;

   typedef struct packed {
      logic [31:0]  addr;
      logic [255:0] line;
      logic [3:0]   cnt;
   } bmem_rd_entry_t;

   function automatic logic [31:0] line_addr(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

endpackage

// File: rtl/bmem_rd_queue.sv
// Circular buffer of pending read snapshots.
// Each live entry counts down to zero.
module bmem_rd_queue
   import bmem_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_push,
   input  bmem_rd_entry_t i_push_entry,
   input  logic           i_pop,
   output bmem_rd_entry_t o_head,
   output logic           o_full,
   output logic           o_empty,
   output logic           o_full_next
);

   localparam int QAW = $clog2(QDEPTH);

   logic [QAW:0]     r_rd_ptr, r_wr_ptr;
   logic [QAW:0]     w_count, w_count_next;
   logic             w_push_ok, w_pop_ok;
   logic [QDEPTH-1:0] w_valid;
   bmem_rd_entry_t   r_q [QDEPTH];

   assign w_count      = r_wr_ptr - r_rd_ptr;
   assign o_empty      = (w_count == '0);
   assign o_full       = (w_count == (QAW+1)'(QDEPTH));
   assign w_push_ok    = i_push & ~o_full;
   assign w_pop_ok     = i_pop & ~o_empty;
   assign w_count_next = w_count + (QAW+1)'(w_push_ok) - (QAW+1)'(w_pop_ok);
   assign o_full_next  = (w_count_next == (QAW+1)'(QDEPTH));
   assign o_head       = r_q[r_rd_ptr[QAW-1:0]];

   // A slot is live when its distance from the head is below the fill level.
   for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_valid
      logic [QAW-1:0] w_off;
      assign w_off       = QAW'(gi) - r_rd_ptr[QAW-1:0];
      assign w_valid[gi] = ({1'b0, w_off} < w_count);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++)
         if (w_valid[i] && r_q[i].cnt != 4'd0) r_q[i].cnt <= r_q[i].cnt - 4'd1;
      if (w_push_ok) r_q[r_wr_ptr[QAW-1:0]] <= i_push_entry;
   end

endmodule

// File: rtl/bmem_responder.sv
// Line-granular burst memory: fixed-latency pipelined reads of four beats,
// four-beat write bursts, and a registered ready for back-pressure.
module bmem_responder
   import bmem_pkg::*;
#(
   parameter int MEM_LINES = 4096,
   parameter int LATENCY   = 4,
   parameter int QDEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bmem_addr,
   input  logic        bmem_read,
   input  logic        bmem_write,
   input  logic [63:0] bmem_wdata,
   output logic        bmem_ready,
   output logic [31:0] bmem_raddr,
   output logic [63:0] bmem_rdata,
   output logic        bmem_rvalid
);

   localparam int OFFW = $clog2(BMEM_LINE_BYTES);
   localparam int IDXW = $clog2(MEM_LINES);

   logic [255:0]          r_mem [MEM_LINES];
   logic [IDXW-1:0]       w_idx, w_mem_idx, r_widx;
   wstate_t               r_wstate, w_wstate_next;
   logic [1:0]            r_wcnt, w_wcnt_next;
   logic [BMEM_BEATS-1:0] w_beat_we;
   logic                  w_rd_acc, w_wr_acc, w_err_rw_both, w_err_wr_gap;
   logic                  r_ready, r_rvalid, r_burst;
   logic [1:0]            r_beat;
   logic [31:0]           r_raddr;
   logic [63:0]           r_rdata;
   bmem_rd_entry_t        w_push_entry, w_head;
   logic                  w_q_full, w_q_empty, w_q_full_next, w_pop, w_start;
   logic                  w_unused;

   assign w_idx         = bmem_addr[OFFW +: IDXW];
   assign w_rd_acc      = bmem_read & r_ready;
   assign w_wr_acc      = bmem_write & r_ready & ~bmem_read;
   assign w_err_rw_both = bmem_read & bmem_write & r_ready;
   assign w_unused      = ^{bmem_addr[OFFW-1:0], w_err_rw_both, w_err_wr_gap, w_q_full};

   // Snapshot at acceptance keeps data ordered with requests even across writes.
   assign w_push_entry = '{addr: line_addr(bmem_addr), line: r_mem[w_idx], cnt: 4'(LATENCY-1)};

   bmem_rd_queue #(.QDEPTH(QDEPTH)) u_rd_queue (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_rd_acc),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_full       (w_q_full),
      .o_empty      (w_q_empty),
      .o_full_next  (w_q_full_next)
   );

   assign w_start = !w_q_empty && (w_head.cnt == 4'd0) && !r_burst;
   assign w_pop   = r_burst && (r_beat == 2'd3);

   always_comb begin
      w_wstate_next = r_wstate;
      w_wcnt_next   = r_wcnt;
      w_mem_idx     = r_widx;
      w_beat_we     = '0;
      w_err_wr_gap  = 1'b0;
      case (r_wstate)
         W_IDLE: if (w_wr_acc) begin
            w_beat_we[0]  = 1'b1;
            w_mem_idx     = w_idx;
            w_wcnt_next   = 2'd1;
            w_wstate_next = W_BEAT;
         end
         W_BEAT: if (bmem_write) begin
            w_beat_we[r_wcnt] = 1'b1;
            w_wcnt_next       = r_wcnt + 2'd1;
            if (r_wcnt == 2'd3) w_wstate_next = W_IDLE;
         end else begin
            w_err_wr_gap  = 1'b1;
            w_wstate_next = W_IDLE;
         end
         default: w_wstate_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wstate <= W_IDLE;
         r_wcnt   <= '0;
         r_widx   <= '0;
      end else begin
         r_wstate <= w_wstate_next;
         r_wcnt   <= w_wcnt_next;
         r_widx   <= w_mem_idx;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < BMEM_BEATS; k++)
         if (w_beat_we[k]) r_mem[w_mem_idx][k*64 +: 64] <= bmem_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready  <= 1'b0;
         r_rvalid <= 1'b0;
         r_burst  <= 1'b0;
         r_beat   <= '0;
         r_raddr  <= '0;
         r_rdata  <= '0;
      end else begin
         r_ready <= !w_q_full_next && (w_wstate_next == W_IDLE);
         if (r_burst) begin
            r_rdata <= w_head.line[int'(r_beat)*64 +: 64];
            r_beat  <= r_beat + 2'd1;
            if (r_beat == 2'd3) r_burst <= 1'b0;
         end else if (w_start) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_head.line[63:0];
            r_raddr  <= w_head.addr;
            r_burst  <= 1'b1;
            r_beat   <= 2'd1;
         end else begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign bmem_ready  = r_ready;
   assign bmem_rvalid = r_rvalid;
   assign bmem_rdata  = r_rdata;
   assign bmem_raddr  = r_raddr;

endmodule
